// File: rtl/uart_host_bridge.sv
// rtl/uart_host_bridge.sv - host-side UART link: stream words to/from 8N1 serial characters
`timescale 1ns/1ps

module uart_host_bridge #(
    parameter real CLK_FREQ   = 100.0e6,
    parameter int  BAUD_RATE  = 115_200,
    parameter int  INP_WIDTH  = 8,
    parameter int  OUT_WIDTH  = 8,
    parameter int  RX_TIMEOUT = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [INP_WIDTH-1:0] s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    output logic [OUT_WIDTH-1:0] m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 txd,
    input  logic                 rxd,
    output logic                 tx_busy,
    output logic                 rx_busy,
    output logic                 rx_error
);

    localparam int BIT_CLKS  = $rtoi(CLK_FREQ / BAUD_RATE);
    localparam int HALF_CLKS = BIT_CLKS / 2;
    localparam int CW        = $clog2(BIT_CLKS + 1);
    localparam int TX_BYTES  = (INP_WIDTH + 7) / 8;
    localparam int TXW       = TX_BYTES * 8;
    localparam int TX_IW     = (TX_BYTES > 1) ? $clog2(TX_BYTES) : 1;
    localparam int RX_BYTES  = (OUT_WIDTH + 7) / 8;
    localparam int RXW       = RX_BYTES * 8;
    localparam int RX_IW     = (RX_BYTES > 1) ? $clog2(RX_BYTES) : 1;
    localparam int TO_CLKS   = RX_TIMEOUT * 10 * BIT_CLKS;
    localparam int TO_W      = $clog2(TO_CLKS + 2);

    generate
        if (BIT_CLKS < 8) begin : g_bad_baud
            $error("uart_host_bridge: CLK_FREQ/BAUD_RATE must be at least 8");
        end
    endgenerate

    // ---------------- TX ----------------
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    tx_state_t        tx_state, tx_state_nxt;
    logic [CW-1:0]    tx_cnt;
    logic [2:0]       tx_bit;
    logic [TX_IW-1:0] tx_idx;
    logic [TXW-1:0]   tx_shift;
    logic             tx_bit_end;
    logic             tx_last_byte;

    assign tx_bit_end    = (tx_cnt == CW'(BIT_CLKS - 1));
    assign tx_last_byte  = (tx_idx == TX_IW'(TX_BYTES - 1));
    assign s_axis_tready = (tx_state == TX_IDLE);
    assign tx_busy       = (tx_state != TX_IDLE);

    always_comb begin
        tx_state_nxt = tx_state;
        txd          = 1'b1;
        case (tx_state)
            TX_IDLE: begin
                if (s_axis_tvalid) tx_state_nxt = TX_START;
            end
            TX_START: begin
                txd = 1'b0;
                if (tx_bit_end) tx_state_nxt = TX_DATA;
            end
            TX_DATA: begin
                txd = tx_shift[0];
                if (tx_bit_end && tx_bit == 3'd7) tx_state_nxt = TX_STOP;
            end
            TX_STOP: begin
                if (tx_bit_end) tx_state_nxt = tx_last_byte ? TX_IDLE : TX_START;
            end
            default: tx_state_nxt = TX_IDLE;
        endcase
    end

    // The shift register moves one bit per data bit, so after eight shifts the next byte sits at the bottom.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
        end else begin
            tx_state <= tx_state_nxt;
            if (tx_state == TX_IDLE) begin
                tx_cnt <= '0;
                tx_bit <= '0;
                tx_idx <= '0;
                if (s_axis_tvalid) tx_shift <= TXW'(s_axis_tdata);
            end else if (tx_bit_end) begin
                tx_cnt <= '0;
                if (tx_state == TX_DATA) begin
                    tx_shift <= tx_shift >> 1;
                    tx_bit   <= tx_bit + 3'd1;
                end
                if (tx_state == TX_STOP && !tx_last_byte) tx_idx <= tx_idx + 1'b1;
            end else begin
                tx_cnt <= tx_cnt + 1'b1;
            end
        end
    end

    // ---------------- RX ----------------
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t        rx_state, rx_state_nxt;
    logic             rxd_meta, rxd_sync;
    logic [CW-1:0]    rx_cnt;
    logic [2:0]       rx_bit;
    logic [7:0]       rx_byte;
    logic [RX_IW-1:0] rx_idx;
    logic [RXW-1:0]   rx_word;
    logic [RXW-1:0]   rx_full;
    logic [TO_W-1:0]  rx_to_cnt;
    logic             rx_half_end, rx_bit_end, rx_cnt_clr;
    logic             rx_stop_sample, rx_good, rx_frame_err, rx_last_slot, rx_timeout_hit;

    assign rx_half_end    = (rx_cnt == CW'(HALF_CLKS - 1));
    assign rx_bit_end     = (rx_cnt == CW'(BIT_CLKS - 1));
    assign rx_cnt_clr     = (rx_state == RX_IDLE) || ((rx_state == RX_START) ? rx_half_end : rx_bit_end);
    assign rx_stop_sample = (rx_state == RX_STOP) && rx_bit_end;
    assign rx_good        = rx_stop_sample && rxd_sync;
    assign rx_frame_err   = rx_stop_sample && !rxd_sync;
    assign rx_last_slot   = (rx_idx == RX_IW'(RX_BYTES - 1));
    assign rx_timeout_hit = (RX_TIMEOUT > 0) && (rx_state == RX_IDLE) && (rx_idx != '0)
                            && (rx_to_cnt == TO_W'(TO_CLKS - 1));
    assign rx_busy        = (rx_state != RX_IDLE);

    always_comb begin
        rx_full = rx_word;
        rx_full[{rx_idx, 3'b000} +: 8] = rx_byte;
    end

    always_comb begin
        rx_state_nxt = rx_state;
        case (rx_state)
            RX_IDLE:  if (!rxd_sync) rx_state_nxt = RX_START;
            RX_START: if (rx_half_end) rx_state_nxt = rxd_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_bit_end && rx_bit == 3'd7) rx_state_nxt = RX_STOP;
            RX_STOP:  if (rx_bit_end) rx_state_nxt = RX_IDLE;
            default:  rx_state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_meta      <= 1'b1;
            rxd_sync      <= 1'b1;
            rx_state      <= RX_IDLE;
            rx_cnt        <= '0;
            rx_bit        <= '0;
            rx_byte       <= '0;
            rx_idx        <= '0;
            rx_word       <= '0;
            rx_to_cnt     <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            rx_error      <= 1'b0;
        end else begin
            rxd_meta <= rxd;
            rxd_sync <= rxd_meta;
            rx_state <= rx_state_nxt;
            rx_cnt   <= rx_cnt_clr ? '0 : rx_cnt + 1'b1;

            if (rx_state == RX_START) rx_bit <= '0;
            if (rx_state == RX_DATA && rx_bit_end) begin
                rx_byte <= {rxd_sync, rx_byte[7:1]};
                rx_bit  <= rx_bit + 3'd1;
            end

            if (RX_TIMEOUT > 0 && rx_state == RX_IDLE && rx_idx != '0 && !rx_timeout_hit)
                rx_to_cnt <= rx_to_cnt + 1'b1;
            else
                rx_to_cnt <= '0;

            if (m_axis_tvalid && m_axis_tready) m_axis_tvalid <= 1'b0;

            // A bad stop bit drops the byte and realigns to slot 0; a full word into a held register is an overrun.
            if (rx_frame_err) begin
                rx_error <= 1'b1;
                rx_idx   <= '0;
            end else if (rx_good) begin
                if (rx_last_slot) begin
                    rx_idx <= '0;
                    if (!m_axis_tvalid || m_axis_tready) begin
                        m_axis_tdata  <= OUT_WIDTH'(rx_full);
                        m_axis_tvalid <= 1'b1;
                    end else begin
                        rx_error <= 1'b1;
                    end
                end else begin
                    rx_word[{rx_idx, 3'b000} +: 8] <= rx_byte;
                    rx_idx <= rx_idx + 1'b1;
                end
            end else if (rx_timeout_hit) begin
                rx_idx <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_host_bridge.sv
// tb/tb_uart_host_bridge.sv - directed self-checking bench for uart_host_bridge
`timescale 1ns/1ps

module tb_uart_host_bridge;

    localparam real CF = 1.6e6;
    localparam int  BR = 100_000;
    localparam int  BC = 16;
    localparam int  NW = 40;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    logic [15:0] a_sdata = '0;
    logic        a_svalid = 1'b0, a_sready, a_mvalid, a_mready = 1'b1;
    logic [11:0] a_mdata;
    logic        a_txd, a_rxd = 1'b1, a_txb, a_rxb, a_err;

    logic [7:0]  b_sdata = '0, b_mdata;
    logic        b_svalid = 1'b0, b_sready, b_mvalid, b_mready = 1'b1;
    logic        b_txd, b_rxd = 1'b1, b_txb, b_rxb, b_err;

    logic [23:0] c_sdata = '0, c_mdata;
    logic        c_svalid = 1'b0, c_sready, c_mvalid, c_mready = 1'b1;
    logic        c_txd, c_txb, c_rxb, c_err;
    logic        rnd_ready = 1'b0;

    uart_host_bridge #(.CLK_FREQ(CF), .BAUD_RATE(BR), .INP_WIDTH(16), .OUT_WIDTH(12), .RX_TIMEOUT(0)) dut_a (
        .clk(clk), .rst(rst),
        .s_axis_tdata(a_sdata), .s_axis_tvalid(a_svalid), .s_axis_tready(a_sready),
        .m_axis_tdata(a_mdata), .m_axis_tvalid(a_mvalid), .m_axis_tready(a_mready),
        .txd(a_txd), .rxd(a_rxd), .tx_busy(a_txb), .rx_busy(a_rxb), .rx_error(a_err));

    uart_host_bridge #(.CLK_FREQ(CF), .BAUD_RATE(BR), .INP_WIDTH(8), .OUT_WIDTH(8), .RX_TIMEOUT(0)) dut_b (
        .clk(clk), .rst(rst),
        .s_axis_tdata(b_sdata), .s_axis_tvalid(b_svalid), .s_axis_tready(b_sready),
        .m_axis_tdata(b_mdata), .m_axis_tvalid(b_mvalid), .m_axis_tready(b_mready),
        .txd(b_txd), .rxd(b_rxd), .tx_busy(b_txb), .rx_busy(b_rxb), .rx_error(b_err));

    uart_host_bridge #(.CLK_FREQ(CF), .BAUD_RATE(BR), .INP_WIDTH(24), .OUT_WIDTH(24), .RX_TIMEOUT(2)) dut_c (
        .clk(clk), .rst(rst),
        .s_axis_tdata(c_sdata), .s_axis_tvalid(c_svalid), .s_axis_tready(c_sready),
        .m_axis_tdata(c_mdata), .m_axis_tvalid(c_mvalid), .m_axis_tready(c_mready),
        .txd(c_txd), .rxd(c_txd), .tx_busy(c_txb), .rx_busy(c_rxb), .rx_error(c_err));

    int          a_beats = 0, b_beats = 0;
    logic [11:0] a_last;
    logic [7:0]  b_last;
    logic [23:0] c_got[$];

    always @(posedge clk) begin
        if (a_mvalid && a_mready) begin a_beats++; a_last = a_mdata; end
        if (b_mvalid && b_mready) begin b_beats++; b_last = b_mdata; end
        if (c_mvalid && c_mready) c_got.push_back(c_mdata);
    end

    initial forever begin
        @(posedge clk); #1;
        c_mready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drive_rx(input int sel, input logic v);
        if (sel == 0) a_rxd = v; else b_rxd = v;
    endtask

    task automatic send_char(input int sel, input logic [7:0] d, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, d, 1'b0};
        for (int i = 0; i < 10; i++) begin drive_rx(sel, f[i]); step(BC); end
        drive_rx(sel, 1'b1);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step(4);
        total++; if ({a_txd, a_sready, a_mvalid, a_txb, a_rxb, a_err} !== 6'b110000) begin bad++; $display("FAIL reset_a_flags: got %b want 110000", {a_txd, a_sready, a_mvalid, a_txb, a_rxb, a_err}); end
        total++; if (a_mdata !== 12'h000) begin bad++; $display("FAIL reset_a_tdata: got %h want 000", a_mdata); end
        total++; if ({b_txd, b_sready, b_mvalid, b_txb, b_rxb, b_err} !== 6'b110000) begin bad++; $display("FAIL reset_b_flags: got %b want 110000", {b_txd, b_sready, b_mvalid, b_txb, b_rxb, b_err}); end
        total++; if (b_mdata !== 8'h00) begin bad++; $display("FAIL reset_b_tdata: got %h want 00", b_mdata); end
        total++; if ({c_txd, c_sready, c_mvalid, c_txb, c_rxb, c_err} !== 6'b110000) begin bad++; $display("FAIL reset_c_flags: got %b want 110000", {c_txd, c_sready, c_mvalid, c_txb, c_rxb, c_err}); end
        rst = 1'b0;
        step(2);
    endtask

    task automatic test_tx_word;
        logic [19:0] fr;
        logic        ok;
        int          guard;
        fr = {1'b1, 8'hA5, 1'b0, 1'b1, 8'h5A, 1'b0};
        a_sdata = 16'hA55A; a_svalid = 1'b1; guard = 0;
        while (!a_sready && guard < 100) begin step(1); guard++; end
        total++; if (guard >= 100) begin bad++; $display("FAIL tx16_ready_wait: tready=%b want 1", a_sready); end
        step(1);
        a_svalid = 1'b0; a_sdata = '0;
        for (int b = 0; b < 20; b++) begin
            ok = 1'b1;
            for (int c = 0; c < BC; c++) begin
                if (a_txd !== fr[b] || a_sready !== 1'b0 || a_txb !== 1'b1) ok = 1'b0;
                step(1);
            end
            total++; if (!ok) begin bad++; $display("FAIL tx16_bit%0d: txd=%b tready=%b busy=%b want txd=%b held 16 cycles", b, a_txd, a_sready, a_txb, fr[b]); end
        end
        total++; if ({a_sready, a_txd, a_txb} !== 3'b110) begin bad++; $display("FAIL tx16_ready_321: got %b want 110", {a_sready, a_txd, a_txb}); end
    endtask

    task automatic test_rx_word;
        int b0;
        b0 = a_beats;
        send_char(0, 8'h34, 1'b1);
        send_char(0, 8'hF2, 1'b1);
        step(40);
        total++; if (a_beats - b0 !== 1) begin bad++; $display("FAIL rx12_beats: got %0d want 1", a_beats - b0); end
        total++; if (a_last !== 12'h234) begin bad++; $display("FAIL rx12_data: got %h want 234", a_last); end
        total++; if (a_err !== 1'b0) begin bad++; $display("FAIL rx12_error: got %b want 0", a_err); end
    endtask

    task automatic test_loopback;
        logic [23:0] exp_q[$];
        logic [23:0] w;
        int          guard;
        c_got.delete();
        rnd_ready = 1'b1;
        for (int n = 0; n < NW; n++) begin
            w = 24'($urandom());
            guard = 0;
            while (!c_sready && guard < 1000) begin step(1); guard++; end
            if (guard >= 1000) begin total++; bad++; $display("FAIL loop_ready_wait: word %0d tready=%b want 1", n, c_sready); end
            c_sdata = w; c_svalid = 1'b1;
            step(1);
            c_svalid = 1'b0;
            exp_q.push_back(w);
        end
        guard = 0;
        while (c_got.size() < NW && guard < 3000) begin step(1); guard++; end
        rnd_ready = 1'b0;
        step(4);
        total++; if (c_got.size() !== NW) begin bad++; $display("FAIL loop_count: got %0d want %0d", c_got.size(), NW); end
        for (int i = 0; i < NW && i < c_got.size(); i++) begin
            total++; if (c_got[i] !== exp_q[i]) begin bad++; $display("FAIL loop_word%0d: got %h want %h", i, c_got[i], exp_q[i]); end
        end
        total++; if (c_err !== 1'b0) begin bad++; $display("FAIL loop_error: got %b want 0", c_err); end
    endtask

    task automatic test_frame_error;
        int b0;
        b0 = b_beats;
        b_mready = 1'b1;
        send_char(1, 8'h55, 1'b0);
        step(40);
        total++; if (b_beats !== b0) begin bad++; $display("FAIL ferr_no_beat: got %0d beats want 0", b_beats - b0); end
        total++; if (b_err !== 1'b1) begin bad++; $display("FAIL ferr_flag: got %b want 1", b_err); end
        send_char(1, 8'hA3, 1'b1);
        step(40);
        total++; if (b_beats - b0 !== 1) begin bad++; $display("FAIL ferr_good_beats: got %0d want 1", b_beats - b0); end
        total++; if (b_last !== 8'hA3) begin bad++; $display("FAIL ferr_good_data: got %h want a3", b_last); end
        total++; if (b_err !== 1'b1) begin bad++; $display("FAIL ferr_sticky: got %b want 1", b_err); end
    endtask

    task automatic test_overrun;
        int b0;
        rst = 1'b1; step(2);
        rst = 1'b0; step(2);
        total++; if (b_err !== 1'b0) begin bad++; $display("FAIL ovr_err_cleared: got %b want 0", b_err); end
        b0 = b_beats;
        b_mready = 1'b0;
        send_char(1, 8'h11, 1'b1);
        step(20);
        send_char(1, 8'h22, 1'b1);
        step(40);
        total++; if (b_mvalid !== 1'b1) begin bad++; $display("FAIL ovr_valid_held: got %b want 1", b_mvalid); end
        total++; if (b_mdata !== 8'h11) begin bad++; $display("FAIL ovr_data_held: got %h want 11", b_mdata); end
        total++; if (b_err !== 1'b1) begin bad++; $display("FAIL ovr_error: got %b want 1", b_err); end
        total++; if (b_beats !== b0) begin bad++; $display("FAIL ovr_no_beat_yet: got %0d want 0", b_beats - b0); end
        b_mready = 1'b1;
        step(6);
        total++; if (b_beats - b0 !== 1) begin bad++; $display("FAIL ovr_release_beats: got %0d want 1", b_beats - b0); end
        total++; if (b_last !== 8'h11) begin bad++; $display("FAIL ovr_release_data: got %h want 11", b_last); end
        total++; if (b_mvalid !== 1'b0) begin bad++; $display("FAIL ovr_valid_cleared: got %b want 0", b_mvalid); end
    endtask

    task automatic test_glitch_tx_reset;
        logic [9:0] fr;
        logic       ok;
        int         b0, guard;
        rst = 1'b1; step(2);
        rst = 1'b0; step(2);
        b0 = b_beats;
        b_rxd = 1'b0; step(4);
        b_rxd = 1'b1; step(40);
        total++; if (b_beats !== b0) begin bad++; $display("FAIL glitch_no_beat: got %0d want 0", b_beats - b0); end
        total++; if ({b_err, b_rxb} !== 2'b00) begin bad++; $display("FAIL glitch_err_busy: got %b want 00", {b_err, b_rxb}); end
        b_sdata = 8'hC3; b_svalid = 1'b1;
        step(1);
        b_svalid = 1'b0;
        step(40);
        total++; if (b_txb !== 1'b1) begin bad++; $display("FAIL txrst_in_flight: busy=%b want 1", b_txb); end
        rst = 1'b1; step(1);
        total++; if ({b_txd, b_sready, b_txb} !== 3'b110) begin bad++; $display("FAIL txrst_after: got %b want 110", {b_txd, b_sready, b_txb}); end
        rst = 1'b0; step(2);
        fr = {1'b1, 8'h96, 1'b0};
        b_sdata = 8'h96; b_svalid = 1'b1; guard = 0;
        while (!b_sready && guard < 100) begin step(1); guard++; end
        step(1);
        b_svalid = 1'b0;
        for (int b = 0; b < 10; b++) begin
            ok = 1'b1;
            for (int c = 0; c < BC; c++) begin
                if (b_txd !== fr[b]) ok = 1'b0;
                step(1);
            end
            total++; if (!ok) begin bad++; $display("FAIL txrst_clean_bit%0d: txd=%b want %b held 16 cycles", b, b_txd, fr[b]); end
        end
        total++; if (b_sready !== 1'b1) begin bad++; $display("FAIL txrst_clean_ready: got %b want 1", b_sready); end
    endtask

    initial begin
        test_reset;
        test_tx_word;
        test_rx_word;
        test_loopback;
        test_frame_error;
        test_overrun;
        test_glitch_tx_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
